uart_rx: RTL

Receive half of the SoC UART: deserialises 8N1 frames from the `rx` pin into bytes and queues them in a small first-word-fall-through FIFO. The CPU reads the FIFO through a 32-bit data port. This block is the counterpart of the existing transmit-only `uart`. It shares the same baud divisor convention, where one bit lasts `UART_BAUD_DIV` clocks.

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_rx_fifo.sv | 48 ++++
 rtl/uart_rx.sv | 129 ++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: framer state encodings, data width and the default
// baud divisor that keeps the TX and RX halves in agreement.
package uart_rx_pkg;

  localparam int UART_DATA_BITS        = 8;
  localparam int UART_BAUD_DIV_DEFAULT = 434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// CPU-side port of the UART receiver: pop/clear requests in, FIFO head and
// status flags out.
interface uart_rx_if;

  logic        re;
  logic        clr_err;
  logic [31:0] rdata;
  logic        empty;
  logic        full;
  logic        overrun;
  logic        ferr;

  modport master (
    output re, clr_err,
    input  rdata, empty, full, overrun, ferr
  );

  modport slave (
    input  re, clr_err,
    output rdata, empty, full, overrun, ferr
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Byte-wide first-word-fall-through FIFO; a write while full is accepted only
// when a pop happens on the same clock.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] wdata,
  input  logic       re,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [7:0]  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr == {~rptr[AW], rptr[AW-1:0]});
  assign do_pop  = re && !empty;
  assign do_push = we && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are valid, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? 8'h00 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx, deframes 8N1 bytes, queues them in a FIFO and
// keeps sticky overrun/framing-error flags for the CPU.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int UART_BAUD_DIV = UART_BAUD_DIV_DEFAULT,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rx,
  uart_rx_if.slave bus
);

  localparam int                CW          = $clog2(UART_BAUD_DIV);
  localparam logic [CW-1:0]     BIT_RELOAD  = CW'(UART_BAUD_DIV - 1);
  localparam logic [CW-1:0]     HALF_RELOAD = CW'(UART_BAUD_DIV / 2 - 1);
  localparam logic [2:0]        LAST_BIT    = 3'(UART_DATA_BITS - 1);

  logic                      rx_m;
  logic                      rx_s;
  rx_state_e                 state;
  logic [CW-1:0]             cnt;
  logic [2:0]                bitidx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      stop_sample;
  logic                      push_req;
  logic                      frame_err;
  logic                      drop;
  logic                      overrun_q;
  logic                      ferr_q;
  logic [7:0]                fifo_rdata;

  // NOTE: non-blocking assignments make each flop capture the pre-edge value
  // of its neighbour; blocking ones would collapse the chain into one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      bitidx <= '0;
      shreg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= HALF_RELOAD;
          end
        end
        START: begin
          if (cnt == '0) begin
            // A start bit that is high again at mid-bit was a glitch.
            if (!rx_s) begin
              state  <= DATA;
              cnt    <= BIT_RELOAD;
              bitidx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg[bitidx] <= rx_s;
            cnt           <= BIT_RELOAD;
            if (bitidx == LAST_BIT) state  <= STOP;
            else                    bitidx <= bitidx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_sample = (state == STOP) && (cnt == '0);
  assign push_req    = stop_sample && rx_s;
  assign frame_err   = stop_sample && !rx_s;
  assign drop        = push_req && bus.full && !bus.re;

  // A coincident error event wins over clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      if (drop)             overrun_q <= 1'b1;
      else if (bus.clr_err) overrun_q <= 1'b0;
      if (frame_err)        ferr_q    <= 1'b1;
      else if (bus.clr_err) ferr_q    <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .we    (push_req),
    .wdata (shreg),
    .re    (bus.re),
    .rdata (fifo_rdata),
    .empty (bus.empty),
    .full  (bus.full)
  );

  assign bus.rdata   = {24'b0, fifo_rdata};
  assign bus.overrun = overrun_q;
  assign bus.ferr    = ferr_q;

endmodule
